// File: rtl/mix_pkg.sv
// mix_pkg: shared payload type and sizing helpers for mix_pipe.
package mix_pkg;
  localparam int MIX_WIDTH = 8;
  typedef struct packed {
    logic [MIX_WIDTH-1:0] data;
    logic [MIX_WIDTH-1:0] sum;
    logic ovf;
    logic c;
  } mix_payload_t;
  function automatic int pay_w(input int w);
    return 2 * w + 2;
  endfunction
  function automatic int occ_w(input int d);
    return $clog2(d + 1);
  endfunction
endpackage

// File: rtl/mix_pipe_if.sv
// mix_pipe_if: input/output handshake bundle for mix_pipe.
interface mix_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);
  import mix_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic sat_mode;
  logic sel;
  logic b;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] sum_out;
  logic ovf_out;
  logic c_out;
  logic [occ_w(DEPTH)-1:0] occupancy;
  modport master (
    output in_valid, data_in, add_a, add_b, sat_mode, sel, b, out_ready,
    input in_ready, out_valid, data_out, sum_out, ovf_out, c_out, occupancy
  );
  modport slave (
    input in_valid, data_in, add_a, add_b, sat_mode, sel, b, out_ready,
    output in_ready, out_valid, data_out, sum_out, ovf_out, c_out, occupancy
  );
endinterface

// File: rtl/mix_pipe_stage.sv
// mix_pipe_stage: one valid+payload register slot with ready pass-back.
module mix_pipe_stage #(
  parameter int PW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  input  logic [PW-1:0] up_pay,
  input  logic          dn_ready,
  output logic          ready,
  output logic          valid,
  output logic [PW-1:0] pay
);
  assign ready = !valid || dn_ready;
  // Payload only moves with a real beat, so bubbles never disturb held data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      pay   <= '0;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) pay <= up_pay;
    end
  end
endmodule

// File: rtl/mix_pipe.sv
// mix_pipe: add/saturate/gate front end feeding a DEPTH-stage valid/ready pipeline.
module mix_pipe
  import mix_pkg::*;
#(
  parameter int WIDTH = MIX_WIDTH,
  parameter int DEPTH = 2
) (
  input logic       clk,
  input logic       rst,
  mix_pipe_if.slave bus
);
  localparam int PW = pay_w(WIDTH);
  localparam int OW = occ_w(DEPTH);
  logic [WIDTH:0]   full_sum;
  logic [WIDTH-1:0] sum;
  logic [PW-1:0]    in_pay;
  logic [DEPTH-1:0] vall;
  logic [OW-1:0]    occ;
  assign full_sum = {1'b0, bus.add_a} + {1'b0, bus.add_b};
  assign sum      = (bus.sat_mode && full_sum[WIDTH]) ? '1 : full_sum[WIDTH-1:0];
  assign in_pay   = {bus.data_in, sum, full_sum[WIDTH], bus.sel & bus.b};
  for (genvar i = 0; i < DEPTH; i++) begin : g
    logic          up_v;
    logic          dn_r;
    logic          v;
    logic          r;
    logic [PW-1:0] up_p;
    logic [PW-1:0] p;
    if (i == 0) begin : h
      assign up_v = bus.in_valid;
      assign up_p = in_pay;
    end else begin : h
      assign up_v = g[i-1].v;
      assign up_p = g[i-1].p;
    end
    if (i == DEPTH - 1) begin : t
      assign dn_r = bus.out_ready;
    end else begin : t
      assign dn_r = g[i+1].r;
    end
    mix_pipe_stage #(.PW(PW)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_v),
      .up_pay   (up_p),
      .dn_ready (dn_r),
      .ready    (r),
      .valid    (v),
      .pay      (p)
    );
    assign vall[i] = v;
  end
  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) occ = occ + OW'(vall[k]);
  end
  assign bus.in_ready  = g[0].r;
  assign bus.out_valid = g[DEPTH-1].v;
  assign {bus.data_out, bus.sum_out, bus.ovf_out, bus.c_out} = g[DEPTH-1].p;
  assign bus.occupancy = occ;
endmodule
